// File: rtl/apb_slave_mux.sv
// APB fan-out from one master to N_SLV slaves. Each access is decoded, replayed
// downstream as SETUP/ACCESS, and terminated locally on unmapped address or timeout.
module apb_slave_mux #(
    parameter int N_SLV   = 4,
    parameter int SEL_LSB = 28,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_psel,
    input  logic                  s_penable,
    input  logic [31:0]           s_paddr,
    input  logic                  s_pwrite,
    input  logic [31:0]           s_pwdata,
    output logic                  s_pready,
    output logic [31:0]           s_prdata,
    output logic                  s_pserr,
    output logic [N_SLV-1:0]      m_psel,
    output logic                  m_penable,
    output logic [31:0]           m_paddr,
    output logic                  m_pwrite,
    output logic [31:0]           m_pwdata,
    input  logic [N_SLV-1:0]      m_pready,
    input  logic [N_SLV*32-1:0]   m_prdata,
    input  logic [N_SLV-1:0]      m_pserr
);
    localparam int              IDXW     = SEL_W + 1;
    localparam logic [31:0]     ERR_DATA = 32'hBADADD12;
    localparam logic [31:0]     LOW_MASK = 32'((64'd1 << SEL_LSB) - 64'd1);
    localparam logic [IDXW-1:0] N_SLV_W  = IDXW'(N_SLV);
    localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t             state_q;
    logic [SEL_W-1:0]   idx_q;
    logic [15:0]        timer_q;
    logic [N_SLV-1:0]   m_psel_q;
    logic               m_penable_q;
    logic [31:0]        m_paddr_q;
    logic               m_pwrite_q;
    logic [31:0]        m_pwdata_q;
    logic               s_pready_q;
    logic [31:0]        s_prdata_q;
    logic               s_pserr_q;

    logic [SEL_W-1:0]   s_idx;
    logic               sel_rdy;
    logic               sel_err;
    logic [31:0]        sel_rdata;

    assign s_idx = s_paddr[SEL_LSB+SEL_W-1:SEL_LSB];

    // Only the slave latched at decode time is listened to.
    always_comb begin
        sel_rdy   = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (idx_q == SEL_W'(i)) begin
                sel_rdy   = m_pready[i];
                sel_err   = m_pserr[i];
                sel_rdata = m_prdata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            timer_q     <= '0;
            m_psel_q    <= '0;
            m_penable_q <= 1'b0;
            m_paddr_q   <= '0;
            m_pwrite_q  <= 1'b0;
            m_pwdata_q  <= '0;
            s_pready_q  <= 1'b0;
            s_prdata_q  <= '0;
            s_pserr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_psel && s_penable) begin
                        if ({1'b0, s_idx} >= N_SLV_W) begin
                            s_pready_q <= 1'b1;
                            s_pserr_q  <= 1'b1;
                            s_prdata_q <= ERR_DATA;
                            state_q    <= DONE;
                        end else begin
                            idx_q       <= s_idx;
                            m_psel_q    <= N_SLV'(1) << s_idx;
                            m_penable_q <= 1'b0;
                            m_paddr_q   <= s_paddr & LOW_MASK;
                            m_pwrite_q  <= s_pwrite;
                            m_pwdata_q  <= s_pwdata;
                            state_q     <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    m_penable_q <= 1'b1;
                    timer_q     <= '0;
                    state_q     <= ACCESS;
                end
                ACCESS: begin
                    timer_q <= timer_q + 16'd1;
                    // A slave answering on the last allowed cycle still wins over the timeout.
                    if (sel_rdy || timer_q == TMO_LAST) begin
                        m_psel_q    <= '0;
                        m_penable_q <= 1'b0;
                        m_paddr_q   <= '0;
                        m_pwrite_q  <= 1'b0;
                        m_pwdata_q  <= '0;
                        s_pready_q  <= 1'b1;
                        state_q     <= DONE;
                        if (sel_rdy) begin
                            s_pserr_q  <= sel_err;
                            s_prdata_q <= m_pwrite_q ? 32'd0 : sel_rdata;
                        end else begin
                            s_pserr_q  <= 1'b1;
                            s_prdata_q <= ERR_DATA;
                        end
                    end
                end
                DONE: begin
                    if (!s_penable) begin
                        s_pready_q <= 1'b0;
                        s_pserr_q  <= 1'b0;
                        s_prdata_q <= '0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_pready  = s_pready_q;
    assign s_prdata  = s_prdata_q;
    assign s_pserr   = s_pserr_q;
    assign m_psel    = m_psel_q;
    assign m_penable = m_penable_q;
    assign m_paddr   = m_paddr_q;
    assign m_pwrite  = m_pwrite_q;
    assign m_pwdata  = m_pwdata_q;
endmodule
